// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst initiator for a single-port synchronous RAM
// (registered read address, 1-cycle read latency, write on RAM_WR at the
// rising edge).
//
// Ports:
//   CLK, RST                 clock, async active-high reset
//   CMD_VALID/READY          burst command handshake (accepted in IDLE only)
//   CMD_WR, CMD_ADDR, CMD_LEN  direction, base address, length-1
//   WR_DATA/VALID/READY      write stream from producer
//   RD_DATA/VALID/READY      read stream to consumer (backpressured)
//   BUSY                     controller not idle
//   RAM_WR, RAM_ADDRESS, RAM_DATA_IN, RAM_DATA_OUT   RAM side
//   ERR                      only with RAM_CTRL_BOUND_CHK_EN: one-cycle pulse
//                            when a burst would run past the top address
//
// Build option: define RAM_CTRL_BOUND_CHK_EN to reject out-of-range bursts;
// otherwise bursts wrap modulo 2**AW.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a command, CMD_READY high
// S_WRITE | streaming producer words into the RAM, one per handshake
// S_READ  | issuing read addresses while the read buffer has room
// S_DRAIN | all addresses issued, waiting for buffer to empty
// S_ERR   | rejected command, ERR high for one cycle (bound check only)
module ram_burst_ctrl #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RST,
`ifdef RAM_CTRL_BOUND_CHK_EN
    output logic          ERR,
`endif
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic          CMD_WR,
    input  logic [AW-1:0] CMD_ADDR,
    input  logic [AW-1:0] CMD_LEN,
    input  logic [DW-1:0] WR_DATA,
    input  logic          WR_VALID,
    output logic          WR_READY,
    output logic [DW-1:0] RD_DATA,
    output logic          RD_VALID,
    input  logic          RD_READY,
    output logic          BUSY,
    output logic          RAM_WR,
    output logic [AW-1:0] RAM_ADDRESS,
    output logic [DW-1:0] RAM_DATA_IN,
    input  logic [DW-1:0] RAM_DATA_OUT
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_READ  = 3'd2,
        S_DRAIN = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] addr, rem, addr_hold;
    logic          inflight;
    logic [DW-1:0] rbuf [2];
    logic          wptr, rptr;
    logic [1:0]    count;
    logic          accept, issue, room, push, pop, bound_err;

`ifdef RAM_CTRL_BOUND_CHK_EN
    logic [AW:0] end_addr;
    assign end_addr  = {1'b0, CMD_ADDR} + {1'b0, CMD_LEN};
    assign bound_err = end_addr[AW];
    assign ERR       = (state == S_ERR);
`else
    assign bound_err = 1'b0;
`endif

    assign RD_VALID = (count != 2'd0);
    assign RD_DATA  = rbuf[rptr];
    assign BUSY     = (state != S_IDLE);
    assign pop      = RD_VALID && RD_READY;
    // The word fetched last cycle lands in the buffer on this edge.
    assign push     = inflight;
    // Occupancy after this edge (buffer + word in flight - word leaving)
    // must stay below 2 so the fetch issued now always has a slot.
    assign room     = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});

    always_comb begin
        state_nxt   = state;
        CMD_READY   = 1'b0;
        accept      = 1'b0;
        WR_READY    = 1'b0;
        RAM_WR      = 1'b0;
        RAM_DATA_IN = '0;
        RAM_ADDRESS = addr_hold;
        issue       = 1'b0;
        case (state)
            S_IDLE: begin
                CMD_READY = !RST;
                accept    = CMD_VALID && !RST;
                if (accept) begin
                    if (bound_err)   state_nxt = S_ERR;
                    else if (CMD_WR) state_nxt = S_WRITE;
                    else             state_nxt = S_READ;
                end
            end
            S_WRITE: begin
                WR_READY    = 1'b1;
                RAM_ADDRESS = addr;
                RAM_DATA_IN = WR_DATA;
                RAM_WR      = WR_VALID;
                if (WR_VALID && rem == '0) state_nxt = S_IDLE;
            end
            S_READ: begin
                issue = room;
                if (room) begin
                    RAM_ADDRESS = addr;
                    if (rem == '0) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight && count == 2'd0) state_nxt = S_IDLE;
            end
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_IDLE;
            addr      <= '0;
            rem       <= '0;
            addr_hold <= '0;
            inflight  <= 1'b0;
            wptr      <= 1'b0;
            rptr      <= 1'b0;
            count     <= 2'd0;
            rbuf[0]   <= '0;
            rbuf[1]   <= '0;
        end else begin
            state     <= state_nxt;
            addr_hold <= RAM_ADDRESS;
            inflight  <= issue;
            if (accept) begin
                addr <= CMD_ADDR;
                rem  <= CMD_LEN;
            end else if (RAM_WR || issue) begin
                addr <= addr + 1'b1;
                rem  <= rem - 1'b1;
            end
            if (push) begin
                rbuf[wptr] <= RAM_DATA_OUT;
                wptr       <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(push && !pop && count == 2'd2));

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Bench for ram_burst_ctrl with a behavioural RAM. Expected write beats and
// expected read words are queued when stimulus is driven and checked when
// the controller produces them.
module tb_ram_burst_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_wr;
    logic [AW-1:0] cmd_addr, cmd_len;
    logic [DW-1:0] wr_data;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_ready;
    logic          busy, ram_wr;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_data_in, ram_data_out;
`ifdef RAM_CTRL_BOUND_CHK_EN
    logic          err;
`endif

    ram_burst_ctrl #(.AW(AW), .DW(DW)) dut (
        .CLK(clk), .RST(rst),
`ifdef RAM_CTRL_BOUND_CHK_EN
        .ERR(err),
`endif
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WR(cmd_wr),
        .CMD_ADDR(cmd_addr), .CMD_LEN(cmd_len),
        .WR_DATA(wr_data), .WR_VALID(wr_valid), .WR_READY(wr_ready),
        .RD_DATA(rd_data), .RD_VALID(rd_valid), .RD_READY(rd_ready),
        .BUSY(busy), .RAM_WR(ram_wr), .RAM_ADDRESS(ram_address),
        .RAM_DATA_IN(ram_data_in), .RAM_DATA_OUT(ram_data_out)
    );

    always #5 clk = ~clk;

    // Single-port RAM: registered read address, write at rising edge.
    logic [DW-1:0] mem [16];
    logic [AW-1:0] ram_addr_q;
    always @(posedge clk) begin
        if (ram_wr) mem[ram_address] <= ram_data_in;
        ram_addr_q <= ram_address;
    end
    assign ram_data_out = mem[ram_addr_q];

    logic [AW+DW-1:0] wr_q [$];
    logic [DW-1:0]    rd_q [$];
    logic [DW-1:0]    shadow [16];
    logic [AW+DW-1:0] wexp;
    int wr_beats = 0;
    int rd_beats = 0;
    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_wr) begin
                wr_beats++;
                if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    wexp = wr_q.pop_front();
                    check("wr_addr", ram_address, wexp[AW+DW-1:DW]);
                    check("wr_data", ram_data_in, wexp[DW-1:0]);
                end
            end
            if (rd_valid && rd_ready) begin
                rd_beats++;
                if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_data", rd_data, rd_q.pop_front());
            end
        end
    end

    task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] l);
        int n = 0;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || rd_q.size() != 0) && n < 300) begin @(posedge clk); #1; n++; end
        if (n >= 300) check("idle_timeout", 0, 1);
    endtask

    task automatic write_burst(input logic [AW-1:0] a, input logic [AW-1:0] l,
                               input logic [DW-1:0] d0, input bit gaps);
        logic [AW-1:0] ad = a;
        int w0 = wr_beats;
        send_cmd(1'b1, a, l);
        for (int i = 0; i <= int'(l); i++) begin
            if (gaps && (i % 2 == 1)) begin
                wr_valid = 1'b0;
                @(negedge clk);
                check("gap_ram_wr", ram_wr, 0);
                check("gap_addr", ram_address, ad);
                @(posedge clk); #1;
            end
            wr_data  = d0 + DW'(i);
            wr_valid = 1'b1;
            wr_q.push_back({ad, wr_data});
            shadow[ad] = wr_data;
            @(posedge clk); #1;
            ad = ad + 1'b1;
        end
        wr_valid = 1'b0;
        wait_idle();
        check("wr_count", wr_beats - w0, int'(l) + 1);
        check("wr_q_empty", wr_q.size(), 0);
    endtask

    // mode 0: RD_READY held high; mode 1: RD_READY pattern 1,0,0,1,0,0...
    task automatic read_burst(input logic [AW-1:0] a, input logic [AW-1:0] l, input int mode);
        logic [AW-1:0] ad = a;
        int r0 = rd_beats;
        int bub = 0;
        int early = 0;
        int n = 0;
        bit started = 0;
        for (int i = 0; i <= int'(l); i++) begin
            rd_q.push_back(shadow[ad]);
            ad = ad + 1'b1;
        end
        rd_ready = (mode == 0);
        send_cmd(1'b0, a, l);
        while ((busy || rd_q.size() != 0) && n < 300) begin
            rd_ready = (mode == 0) ? 1'b1 : (n % 3 == 0);
            @(negedge clk); #1;
            if (started && (rd_beats - r0) < int'(l) + 1 && !rd_valid) bub++;
            if (rd_valid) started = 1;
            if (cmd_ready && (rd_beats - r0) < int'(l) + 1) early++;
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) check("rd_timeout", 0, 1);
        rd_ready = 1'b0;
        check("rd_count", rd_beats - r0, int'(l) + 1);
        if (mode == 0) check("rd_bubbles", bub, 0);
        check("cmd_ready_early", early, 0);
        check("busy_after_rd", busy, 0);
        check("rd_valid_after_rd", rd_valid, 0);
    endtask

    initial begin
        int n;
        int r0;
        int w0;
        for (int i = 0; i < 16; i++) begin mem[i] = '0; shadow[i] = '0; end
        rst = 1'b1; cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 0; rd_ready = 0;
        #2;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ram_wr", ram_wr, 0);
        check("rst_ram_addr", ram_address, 0);
        check("rst_ram_din", ram_data_in, 0);
`ifdef RAM_CTRL_BOUND_CHK_EN
        check("rst_err", err, 0);
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;

        // single word write then read
        write_burst(4'd3, 4'd0, 8'hA5, 0);
        read_burst(4'd3, 4'd0, 0);

        // full 16-word burst
        write_burst(4'd0, 4'd15, 8'h10, 0);
        read_burst(4'd0, 4'd15, 0);

        // wrap past the top address
`ifdef RAM_CTRL_BOUND_CHK_EN
        w0 = wr_beats;
        send_cmd(1'b1, 4'd14, 4'd3);
        @(negedge clk);
        check("err_pulse_wr", err, 1);
        @(negedge clk);
        check("err_clear_wr", err, 0);
        check("err_idle_wr", cmd_ready, 1);
        check("err_no_ram_wr", wr_beats - w0, 0);
        r0 = rd_beats;
        rd_ready = 1'b1;
        send_cmd(1'b0, 4'd14, 4'd3);
        @(negedge clk);
        check("err_pulse_rd", err, 1);
        check("err_no_rd_valid", rd_valid, 0);
        @(negedge clk);
        check("err_clear_rd", err, 0);
        check("err_no_rd_beats", rd_beats - r0, 0);
        @(posedge clk); #1;
        rd_ready = 1'b0;
`else
        write_burst(4'd14, 4'd3, 8'hE0, 0);
        read_burst(4'd14, 4'd3, 0);
`endif

        // read backpressure, write gaps
        read_burst(4'd0, 4'd7, 1);
        write_burst(4'd8, 4'd3, 8'h80, 1);
        read_burst(4'd8, 4'd3, 1);

        // reset in the middle of a read burst
        r0 = rd_beats;
        for (int i = 0; i < 8; i++) rd_q.push_back(shadow[i]);
        rd_ready = 1'b1;
        send_cmd(1'b0, 4'd0, 4'd7);
        n = 0;
        while ((rd_beats - r0) < 3 && n < 50) begin @(negedge clk); #1; n++; end
        check("mid_rst_beats", rd_beats - r0, 3);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("mid_rst_rd_valid", rd_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        rd_q.delete();
        rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        read_burst(4'd5, 4'd0, 0);

        // command held high during a read burst
        r0 = rd_beats;
        for (int i = 0; i < 4; i++) rd_q.push_back(shadow[i]);
        rd_q.push_back(shadow[9]);
        rd_ready = 1'b1;
        send_cmd(1'b0, 4'd0, 4'd3);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd9; cmd_len = 4'd0;
        n = 0;
        while (n < 100) begin
            @(negedge clk); #1;
            if (cmd_ready) break;
            n++;
        end
        check("blk_ready_seen", cmd_ready, 1);
        check("blk_words_before_ready", rd_beats - r0, 4);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle();
        check("blk_total_words", rd_beats - r0, 5);
        rd_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
